// File: rtl/rstack_arbiter_if.sv
// Request/grant bundle between the two return-stack requesters and the arbiter.
// master drives requests (sequencer/datapath side); slave is the arbiter.
interface rstack_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  seq_req;
    logic                  seq_op;
    logic [DATA_WIDTH-1:0] seq_wdata;
    logic                  seq_gnt;
    logic [DATA_WIDTH-1:0] seq_rdata;

    logic                  dp_req;
    logic [1:0]            dp_op;
    logic [DATA_WIDTH-1:0] dp_wdata;
    logic                  dp_gnt;
    logic [DATA_WIDTH-1:0] dp_rdata;

    modport master (
        output seq_req, seq_op, seq_wdata, dp_req, dp_op, dp_wdata,
        input  seq_gnt, seq_rdata, dp_gnt, dp_rdata
    );

    modport slave (
        input  seq_req, seq_op, seq_wdata, dp_req, dp_op, dp_wdata,
        output seq_gnt, seq_rdata, dp_gnt, dp_rdata
    );
endinterface

// File: rtl/rstack_arbiter.sv
// Round-robin arbiter and sequencer for the return stack: serialises sequencer and datapath
// requests into push/pop strobes, tracks depth and records the first overflow/underflow.
module rstack_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH_BITS = 10
) (
    input  logic                  write_clock,
    input  logic                  reset,
    rstack_arbiter_if.slave       req_if,
    output logic [DATA_WIDTH-1:0] rs_data_o,
    output logic                  rs_push_o,
    output logic                  rs_pop_o,
    input  logic [DATA_WIDTH-1:0] rs_q_i,
    output logic [DEPTH_BITS:0]   depth_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    typedef enum logic [1:0] {StIdle, StExec, StRead} state_e;
    // Encoding matches dp_op so a datapath request latches directly.
    typedef enum logic [1:0] {OpPush = 2'b00, OpPop = 2'b01, OpPeek = 2'b10, OpDrop = 2'b11} op_e;

    localparam logic                OwnSeq       = 1'b0;
    localparam logic                OwnDp        = 1'b1;
    localparam logic [1:0]          ErrNone      = 2'b00;
    localparam logic [1:0]          ErrOverflow  = 2'b01;
    localparam logic [1:0]          ErrUnderflow = 2'b10;
    localparam logic [DEPTH_BITS:0] MaxDepth     = {1'b1, {DEPTH_BITS{1'b0}}};

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] seq_rdata_q, seq_rdata_d;
    logic [DATA_WIDTH-1:0] dp_rdata_q, dp_rdata_d;
    logic [DEPTH_BITS:0]   depth_q, depth_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic done;
    logic rs_push;
    logic rs_pop;
    logic pick_dp;
    logic is_full;
    logic is_empty;

    assign is_full  = (depth_q == MaxDepth);
    assign is_empty = (depth_q == '0);
    // On a tie, serve whoever was not served last.
    assign pick_dp  = req_if.dp_req && (!req_if.seq_req || (last_owner_q == OwnSeq));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wdata_d      = wdata_q;
        seq_rdata_d  = seq_rdata_q;
        dp_rdata_d   = dp_rdata_q;
        depth_d      = depth_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        done         = 1'b0;
        rs_push      = 1'b0;
        rs_pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_if.seq_req || req_if.dp_req) begin
                    owner_d      = pick_dp;
                    last_owner_d = pick_dp;
                    op_d         = pick_dp ? op_e'(req_if.dp_op)
                                           : (req_if.seq_op ? OpPop : OpPush);
                    wdata_d      = pick_dp ? req_if.dp_wdata : req_if.seq_wdata;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (op_q == OpPush) begin
                    done    = 1'b1;
                    state_d = StIdle;
                    if (!is_full) begin
                        rs_push = 1'b1;
                        depth_d = depth_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (err_code_q == ErrNone) err_code_d = ErrOverflow;
                    end
                end else if (is_empty) begin
                    done  = 1'b1;
                    state_d = StIdle;
                    err_d = 1'b1;
                    if (err_code_q == ErrNone) err_code_d = ErrUnderflow;
                    if (owner_q == OwnSeq) seq_rdata_d = '0;
                    else                   dp_rdata_d  = '0;
                end else begin
                    state_d = StRead;
                end
            end
            StRead: begin
                // rs_q has settled: the last strobe was at least two cycles ago.
                done    = 1'b1;
                state_d = StIdle;
                if (op_q != OpPeek) begin
                    rs_pop  = 1'b1;
                    depth_d = depth_q - 1'b1;
                end
                if (owner_q == OwnSeq)    seq_rdata_d = rs_q_i;
                else if (op_q != OpDrop)  dp_rdata_d  = rs_q_i;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge write_clock) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= OpPush;
            owner_q      <= OwnSeq;
            last_owner_q <= OwnDp;
            wdata_q      <= '0;
            seq_rdata_q  <= '0;
            dp_rdata_q   <= '0;
            depth_q      <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ErrNone;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wdata_q      <= wdata_d;
            seq_rdata_q  <= seq_rdata_d;
            dp_rdata_q   <= dp_rdata_d;
            depth_q      <= depth_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign req_if.seq_gnt   = done && (owner_q == OwnSeq);
    assign req_if.dp_gnt    = done && (owner_q == OwnDp);
    assign req_if.seq_rdata = seq_rdata_d;
    assign req_if.dp_rdata  = dp_rdata_d;

    assign rs_data_o  = wdata_q;
    assign rs_push_o  = rs_push;
    assign rs_pop_o   = rs_pop;
    assign depth_o    = depth_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_rstack_arbiter.sv
// Bench for rstack_arbiter: directed scenarios then random traffic, checked against a
// queue-based model of the return stack with round-robin ownership.
module tb_rstack_arbiter;

    logic        write_clock;
    logic        reset;
    logic [15:0] rs_data;
    logic        rs_push;
    logic        rs_pop;
    logic [15:0] rs_q;
    logic [10:0] depth;
    logic        err;
    logic [1:0]  err_code;

    rstack_arbiter_if #(.DATA_WIDTH(16)) bus ();

    rstack_arbiter #(.DATA_WIDTH(16), .DEPTH_BITS(10)) dut (
        .write_clock (write_clock),
        .reset       (reset),
        .req_if      (bus),
        .rs_data_o   (rs_data),
        .rs_push_o   (rs_push),
        .rs_pop_o    (rs_pop),
        .rs_q_i      (rs_q),
        .depth_o     (depth),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    initial write_clock = 1'b0;
    always #5 write_clock = ~write_clock;

    // Stack memory: top-of-stack is registered, valid the cycle after a strobe.
    logic [15:0] mem [0:1023];
    int          sp;
    always @(posedge write_clock) begin
        if (reset) begin
            sp   <= 0;
            rs_q <= '0;
        end else if (rs_push) begin
            mem[sp] <= rs_data;
            sp      <= sp + 1;
            rs_q    <= rs_data;
        end else if (rs_pop) begin
            sp   <= sp - 1;
            rs_q <= (sp >= 2) ? mem[sp-2] : 16'h0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] rq [$];
    logic [1:0]  ref_code;
    logic        ref_err;
    logic [15:0] ref_seq_rd;
    logic [15:0] ref_dp_rd;
    bit          ref_last;  // 1: datapath served last

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] kind_of(input bit is_dp, input logic [1:0] op);
        return is_dp ? op : {1'b0, op[0]};
    endfunction

    task automatic model_op(input bit is_dp, input logic [1:0] kind, input logic [15:0] wd,
                            output int lat, output bit push, output bit pop);
        logic [15:0] val;
        push = 0;
        pop  = 0;
        lat  = 1;
        if (kind == 2'b00) begin
            if (rq.size() < 1024) begin
                push = 1;
                rq.push_back(wd);
            end else begin
                ref_err = 1'b1;
                if (ref_code == 2'b00) ref_code = 2'b01;
            end
        end else if (rq.size() == 0) begin
            ref_err = 1'b1;
            if (ref_code == 2'b00) ref_code = 2'b10;
            if (is_dp) ref_dp_rd = '0;
            else       ref_seq_rd = '0;
        end else begin
            lat = 2;
            val = rq[rq.size()-1];
            if (kind != 2'b10) begin
                pop = 1;
                void'(rq.pop_back());
            end
            if (!is_dp)              ref_seq_rd = val;
            else if (kind != 2'b11)  ref_dp_rd  = val;
        end
        ref_last = is_dp;
    endtask

    task automatic set_req(input bit is_dp, input logic val, input logic [1:0] op,
                           input logic [15:0] wd);
        if (is_dp) begin
            bus.dp_req   = val;
            bus.dp_op    = op;
            bus.dp_wdata = wd;
        end else begin
            bus.seq_req   = val;
            bus.seq_op    = op[0];
            bus.seq_wdata = wd;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(1'b0, 1'b0, 2'b00, 16'h0);
        set_req(1'b1, 1'b0, 2'b00, 16'h0);
        repeat (2) @(negedge write_clock);
        reset = 1'b0;
        rq.delete();
        ref_code   = 2'b00;
        ref_err    = 1'b0;
        ref_seq_rd = '0;
        ref_dp_rd  = '0;
        ref_last   = 1'b1;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_seq_gnt"}, 32'(bus.seq_gnt), 32'd0);
        chk({pfx, "_dp_gnt"}, 32'(bus.dp_gnt), 32'd0);
        chk({pfx, "_rs_push"}, 32'(rs_push), 32'd0);
        chk({pfx, "_rs_pop"}, 32'(rs_pop), 32'd0);
        chk({pfx, "_rs_data"}, 32'(rs_data), 32'd0);
        chk({pfx, "_seq_rdata"}, 32'(bus.seq_rdata), 32'd0);
        chk({pfx, "_dp_rdata"}, 32'(bus.dp_rdata), 32'd0);
        chk({pfx, "_depth"}, 32'(depth), 32'd0);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    task automatic check_after();
        @(negedge write_clock);
        chk("depth", 32'(depth), 32'(rq.size()));
        chk("err", 32'(err), 32'(ref_err));
        chk("err_code", 32'(err_code), 32'(ref_code));
    endtask

    task automatic run_op(input bit is_dp, input logic [1:0] op, input logic [15:0] wd);
        int exp_lat, lat, early;
        bit exp_push, exp_pop, seen;
        logic g, got_push, got_pop, other_g;
        logic [15:0] got_rd, got_data;
        model_op(is_dp, kind_of(is_dp, op), wd, exp_lat, exp_push, exp_pop);
        set_req(is_dp, 1'b1, op, wd);
        lat = 0; early = 0; seen = 0;
        got_push = 0; got_pop = 0; other_g = 0; got_rd = '0; got_data = '0;
        while (!seen && lat < 12) begin
            @(negedge write_clock);
            lat++;
            g = is_dp ? bus.dp_gnt : bus.seq_gnt;
            if (g) begin
                seen     = 1;
                got_push = rs_push;
                got_pop  = rs_pop;
                got_data = rs_data;
                got_rd   = is_dp ? bus.dp_rdata : bus.seq_rdata;
                other_g  = is_dp ? bus.seq_gnt : bus.dp_gnt;
            end else begin
                early += int'(rs_push | rs_pop);
            end
        end
        set_req(is_dp, 1'b0, 2'($urandom), 16'($urandom));
        chk("gnt_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("gnt_latency", 32'(lat), 32'(exp_lat));
            chk("rs_push", 32'(got_push), 32'(exp_push));
            chk("rs_pop", 32'(got_pop), 32'(exp_pop));
            chk("other_gnt", 32'(other_g), 32'd0);
            chk("rdata", 32'(got_rd), 32'(is_dp ? ref_dp_rd : ref_seq_rd));
            if (exp_push) chk("rs_data", 32'(got_data), 32'(wd));
        end
        chk("early_strobe", 32'(early), 32'd0);
        check_after();
    endtask

    task automatic run_tie(input logic [1:0] dop, input logic [15:0] dwd,
                           input logic sop, input logic [15:0] swd);
        int  l_s, l_d, exp_t_s, exp_t_d, t_s, t_d, cyc;
        bit  p_s, q_s, p_d, q_d;
        logic gp_s, gq_s, gp_d, gq_d;
        logic [15:0] rd_s, rd_d, dat_s, dat_d;
        if (ref_last) begin
            model_op(1'b0, kind_of(1'b0, {1'b0, sop}), swd, l_s, p_s, q_s);
            model_op(1'b1, dop, dwd, l_d, p_d, q_d);
            exp_t_s = l_s;
            exp_t_d = l_s + 1 + l_d;
        end else begin
            model_op(1'b1, dop, dwd, l_d, p_d, q_d);
            model_op(1'b0, kind_of(1'b0, {1'b0, sop}), swd, l_s, p_s, q_s);
            exp_t_d = l_d;
            exp_t_s = l_d + 1 + l_s;
        end
        set_req(1'b0, 1'b1, {1'b0, sop}, swd);
        set_req(1'b1, 1'b1, dop, dwd);
        t_s = 0; t_d = 0; cyc = 0;
        gp_s = 0; gq_s = 0; gp_d = 0; gq_d = 0;
        rd_s = '0; rd_d = '0; dat_s = '0; dat_d = '0;
        while ((t_s == 0 || t_d == 0) && cyc < 20) begin
            @(negedge write_clock);
            cyc++;
            if (bus.seq_gnt && t_s == 0) begin
                t_s = cyc; gp_s = rs_push; gq_s = rs_pop; rd_s = bus.seq_rdata; dat_s = rs_data;
                set_req(1'b0, 1'b0, 2'($urandom), 16'($urandom));
            end
            if (bus.dp_gnt && t_d == 0) begin
                t_d = cyc; gp_d = rs_push; gq_d = rs_pop; rd_d = bus.dp_rdata; dat_d = rs_data;
                set_req(1'b1, 1'b0, 2'($urandom), 16'($urandom));
            end
        end
        set_req(1'b0, 1'b0, 2'b00, 16'h0);
        set_req(1'b1, 1'b0, 2'b00, 16'h0);
        chk("tie_seq_time", 32'(t_s), 32'(exp_t_s));
        chk("tie_dp_time", 32'(t_d), 32'(exp_t_d));
        chk("tie_seq_push", 32'(gp_s), 32'(p_s));
        chk("tie_seq_pop", 32'(gq_s), 32'(q_s));
        chk("tie_dp_push", 32'(gp_d), 32'(p_d));
        chk("tie_dp_pop", 32'(gq_d), 32'(q_d));
        chk("tie_seq_rdata", 32'(rd_s), 32'(ref_seq_rd));
        chk("tie_dp_rdata", 32'(rd_d), 32'(ref_dp_rd));
        if (p_s) chk("tie_seq_rs_data", 32'(dat_s), 32'(swd));
        if (p_d) chk("tie_dp_rs_data", 32'(dat_d), 32'(dwd));
        check_after();
    endtask

    initial begin
        reset = 1'b1;
        set_req(1'b0, 1'b0, 2'b00, 16'h0);
        set_req(1'b1, 1'b0, 2'b00, 16'h0);

        // Reset values, then a single CALL
        do_reset();
        check_reset_values("rst");
        run_op(1'b0, 2'b00, 16'h1234);

        // >R then R@: peek returns the value without popping
        do_reset();
        run_op(1'b1, 2'b00, 16'hAAAA);
        run_op(1'b1, 2'b10, 16'h0);

        // Simultaneous RET and R> at depth 2: sequencer wins the first tie
        do_reset();
        run_op(1'b1, 2'b00, 16'h1111);
        run_op(1'b1, 2'b00, 16'h2222);
        run_tie(2'b01, 16'h0, 1'b1, 16'h0);

        // Underflow first, then a later overflow must not overwrite the code
        do_reset();
        run_op(1'b0, 2'b01, 16'h0);
        for (int i = 0; i < 1024; i++) run_op(1'($urandom_range(0, 1)), 2'b00, 16'($urandom));
        run_op(1'b1, 2'b00, 16'hBEEF);
        chk("sticky_underflow", 32'(err_code), 32'd2);

        // Clean overflow
        do_reset();
        for (int i = 0; i < 1024; i++) run_op(1'b1, 2'b00, 16'($urandom));
        run_op(1'b1, 2'b00, 16'hCAFE);
        chk("overflow_depth", 32'(depth), 32'd1024);

        // Reset during the READ cycle of an R>
        do_reset();
        run_op(1'b1, 2'b00, 16'h5555);
        set_req(1'b1, 1'b1, 2'b01, 16'h0);
        repeat (2) @(negedge write_clock);
        chk("read_cycle_gnt", 32'(bus.dp_gnt), 32'd1);
        reset = 1'b1;
        set_req(1'b1, 1'b0, 2'b00, 16'h0);
        @(negedge write_clock);
        check_reset_values("abort");
        do_reset();

        // Random traffic with occasional simultaneous requests
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_tie(2'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
            else
                run_op(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
